// File: rtl/mux_display_decoder_if.sv
// ---------------------------------------------------------------------------
// mux_display_decoder_if
// Raw multiplexed 7-segment display bus as seen at the decoder's pins.
//   seg_in  [6:0] segment lines, bit0 = a .. bit6 = g
//   dp_in         decimal-point line
//   sel_in  [3:0] one-hot digit selector (1 = min units .. 8 = hrs tens)
//   neg_seg       1 = seg_in/dp_in are active-low
//   neg_sel       1 = sel_in is active-low
// master drives the bus (display side / bench), slave receives it (decoder).
// ---------------------------------------------------------------------------
interface mux_display_decoder_if;
    logic [6:0] seg_in;
    logic       dp_in;
    logic [3:0] sel_in;
    logic       neg_seg;
    logic       neg_sel;

    modport master (
        output seg_in,
        output dp_in,
        output sel_in,
        output neg_seg,
        output neg_sel
    );

    modport slave (
        input seg_in,
        input dp_in,
        input sel_in,
        input neg_seg,
        input neg_sel
    );
endinterface

// File: rtl/mux_display_decoder.sv
// ---------------------------------------------------------------------------
// mux_display_decoder
// Receiving end of a multiplexed 7-segment HH:MM clock display. Samples the
// display bus, decodes each digit slot back to BCD, reassembles the time plus
// the four dot LEDs and publishes it only after STABLE_FRAMES identical,
// error-free scan frames.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   disp             display bus (slave modport)
//   min_u/min_d      decoded minute units / tens
//   hrs_u/hrs_d      decoded hour units / tens
//   dots             {dp@sel1, dp@sel2, dp@sel4, dp@sel8}
//   time_valid       outputs hold a confirmed time
//   frame_stb        one-cycle pulse whenever the outputs are loaded
//   decode_err       last completed frame was bad (sticky until next load)
//   scan_lost        no legal selector transition for SCAN_TIMEOUT cycles
// Pipeline: input register -> transition detect / slot commit -> frame
// evaluation and output register.
// ---------------------------------------------------------------------------
module mux_display_decoder #(
    parameter int SCAN_TIMEOUT  = 256,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    mux_display_decoder_if.slave        disp,
    output logic [3:0]                  min_u,
    output logic [3:0]                  min_d,
    output logic [3:0]                  hrs_u,
    output logic [3:0]                  hrs_d,
    output logic [3:0]                  dots,
    output logic                        time_valid,
    output logic                        frame_stb,
    output logic                        decode_err,
    output logic                        scan_lost
);

    localparam int            TW       = $clog2(SCAN_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(SCAN_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(SCAN_TIMEOUT - 1);
    localparam logic [3:0]    STABLE_N = 4'(STABLE_FRAMES);

    // Returns {valid, digit}; unknown patterns decode as invalid zero.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7C:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h67:   r = 5'h19;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

    // Stage 1
    logic [6:0]    seg_s1_r;
    logic          dp_s1_r;
    logic [3:0]    sel_s1_r;

    // Scan tracking
    logic [3:0]    prev_sel_r;
    logic [4:0]    hold_r;
    logic          hold_dp_r;
    logic [4:0]    slot_r [4];
    logic [3:0]    slot_dp_r;
    logic [3:0]    mask_r;
    logic          frame_end_r;
    logic [TW-1:0] tmo_cnt_r;

    // Candidate / stability
    logic [19:0]   cand_r;
    logic [3:0]    match_r;

    logic          sel_ok_s;
    logic          prev_ok_s;
    logic          trans_s;
    logic          legal_s;
    logic [3:0]    mask_commit_s;
    logic          frame_end_s;
    logic          tmo_hit_s;
    logic [1:0]    commit_idx_s;

    logic [15:0]   frame_word_s;
    logic [3:0]    frame_dots_s;
    logic [7:0]    hrs_val_s;
    logic          good_s;
    logic          same_s;
    logic [3:0]    match_nxt_s;

    // Input register with polarity normalisation
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1_r <= 7'h00;
            dp_s1_r  <= 1'b0;
            sel_s1_r <= 4'h0;
        end else begin
            seg_s1_r <= disp.seg_in ^ {7{disp.neg_seg}};
            dp_s1_r  <= disp.dp_in ^ disp.neg_seg;
            sel_s1_r <= disp.sel_in ^ {4{disp.neg_sel}};
        end
    end

    // Classify the current selector against the previous slot
    always_comb begin
        sel_ok_s      = is_onehot(sel_s1_r);
        prev_ok_s     = is_onehot(prev_sel_r);
        trans_s       = sel_ok_s && prev_ok_s && (sel_s1_r != prev_sel_r);
        legal_s       = trans_s && (sel_s1_r == {prev_sel_r[2:0], prev_sel_r[3]});
        mask_commit_s = mask_r | prev_sel_r;
        // Only the wrap 8->1 can close a frame, and only after all slots committed.
        frame_end_s   = legal_s && (prev_sel_r == 4'b1000) && (mask_commit_s == 4'b1111);
        // A legal transition restarts the counter, so it masks a coinciding timeout.
        tmo_hit_s     = !legal_s && (tmo_cnt_r == TMO_LAST);
        case (prev_sel_r)
            4'b0001: commit_idx_s = 2'd0;
            4'b0010: commit_idx_s = 2'd1;
            4'b0100: commit_idx_s = 2'd2;
            4'b1000: commit_idx_s = 2'd3;
            default: commit_idx_s = 2'd0;
        endcase
    end

    // Slot hold/commit, visited mask and scan timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sel_r  <= 4'h0;
            hold_r      <= 5'h00;
            hold_dp_r   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= 5'h00;
            end
            slot_dp_r   <= 4'h0;
            mask_r      <= 4'h0;
            frame_end_r <= 1'b0;
            tmo_cnt_r   <= '0;
        end else begin
            frame_end_r <= frame_end_s;
            // Hold tracks every one-hot cycle so the last dwell cycle is what commits.
            if (sel_ok_s) begin
                hold_r     <= seg_decode(seg_s1_r);
                hold_dp_r  <= dp_s1_r;
                prev_sel_r <= sel_s1_r;
            end
            if (trans_s) begin
                slot_r[commit_idx_s]    <= hold_r;
                slot_dp_r[commit_idx_s] <= hold_dp_r;
            end
            if (tmo_hit_s || (trans_s && !legal_s) || frame_end_s) begin
                mask_r <= 4'h0;
            end else if (trans_s) begin
                mask_r <= mask_commit_s;
            end
            if (legal_s) begin
                tmo_cnt_r <= '0;
            end else if (tmo_cnt_r != TMO_MAX) begin
                tmo_cnt_r <= tmo_cnt_r + 1'b1;
            end
        end
    end

    // Evaluate the committed frame and its relation to the candidate
    always_comb begin
        frame_word_s = {slot_r[3][3:0], slot_r[2][3:0], slot_r[1][3:0], slot_r[0][3:0]};
        frame_dots_s = {slot_dp_r[0], slot_dp_r[1], slot_dp_r[2], slot_dp_r[3]};
        hrs_val_s    = {1'b0, slot_r[3][3:0], 3'b000} + {3'b000, slot_r[3][3:0], 1'b0}
                     + {4'b0000, slot_r[2][3:0]};
        good_s       = slot_r[0][4] && slot_r[1][4] && slot_r[2][4] && slot_r[3][4]
                     && (slot_r[1][3:0] <= 4'd5) && (slot_r[3][3:0] <= 4'd2)
                     && (hrs_val_s <= 8'd23);
        same_s       = ({frame_word_s, frame_dots_s} == cand_r);
        if (!same_s) begin
            match_nxt_s = 4'd1;
        end else if (match_r == 4'hF) begin
            match_nxt_s = match_r;
        end else begin
            match_nxt_s = match_r + 4'd1;
        end
    end

    // Candidate, match count and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_r     <= 20'h00000;
            match_r    <= 4'h0;
            min_u      <= 4'h0;
            min_d      <= 4'h0;
            hrs_u      <= 4'h0;
            hrs_d      <= 4'h0;
            dots       <= 4'h0;
            time_valid <= 1'b0;
            frame_stb  <= 1'b0;
            decode_err <= 1'b0;
            scan_lost  <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            if (frame_end_r) begin
                if (good_s) begin
                    match_r <= match_nxt_s;
                    if (!same_s) begin
                        cand_r <= {frame_word_s, frame_dots_s};
                    end
                    if (match_nxt_s >= STABLE_N) begin
                        min_u      <= frame_word_s[3:0];
                        min_d      <= frame_word_s[7:4];
                        hrs_u      <= frame_word_s[11:8];
                        hrs_d      <= frame_word_s[15:12];
                        dots       <= frame_dots_s;
                        time_valid <= 1'b1;
                        frame_stb  <= 1'b1;
                        decode_err <= 1'b0;
                        scan_lost  <= 1'b0;
                    end
                end else begin
                    decode_err <= 1'b1;
                    match_r    <= 4'h0;
                end
            end else if (tmo_hit_s) begin
                scan_lost  <= 1'b1;
                time_valid <= 1'b0;
                match_r    <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_mux_display_decoder.sv
// ---------------------------------------------------------------------------
// tb_mux_display_decoder
// Self-checking bench for mux_display_decoder. Display scans are generated
// from a digit->segment table; every expected output load is queued before
// the scan that should produce it and popped by a monitor on frame_stb.
// ---------------------------------------------------------------------------
module tb_mux_display_decoder;

    localparam int DW = 33;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] min_u, min_d, hrs_u, hrs_d, dots;
    logic       time_valid, frame_stb, decode_err, scan_lost;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  dots;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    mux_display_decoder_if disp();

    mux_display_decoder #(.SCAN_TIMEOUT(256), .STABLE_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .disp       (disp),
        .min_u      (min_u),
        .min_d      (min_d),
        .hrs_u      (hrs_u),
        .hrs_d      (hrs_d),
        .dots       (dots),
        .time_valid (time_valid),
        .frame_stb  (frame_stb),
        .decode_err (decode_err),
        .scan_lost  (scan_lost)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7C;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h67;
            default: return 7'h00;
        endcase
    endfunction

    // Scoreboard: every output load must match the oldest queued expectation
    always @(negedge clk) begin
        if (frame_stb === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stb_unexpected: frame_stb with time %h%h:%h%h, none expected",
                         hrs_d, hrs_u, min_d, min_u);
            end else begin
                mon_e = exp_q.pop_front();
                if ({hrs_d, hrs_u, min_d, min_u, dots, time_valid, decode_err, scan_lost}
                    !== {mon_e.word, mon_e.dots, 3'b100}) begin
                    n_fail++;
                    $display("FAIL stb_frame: got %h%h:%h%h dots %b tv/err/lost %b%b%b, expected %h dots %b tv/err/lost 100",
                             hrs_d, hrs_u, min_d, min_u, dots, time_valid, decode_err, scan_lost,
                             mon_e.word, mon_e.dots);
                end
            end
        end
    end

    // Drive one slot for n cycles (called and returning on a falling edge)
    task automatic drive_sel(input logic [3:0] sel, input logic [15:0] word,
                             input logic [3:0] dts, input int bad, input int n);
        int         idx;
        logic [6:0] seg;
        case (sel)
            4'b0001: idx = 0;
            4'b0010: idx = 1;
            4'b0100: idx = 2;
            default: idx = 3;
        endcase
        seg = (idx == bad) ? 7'h00 : enc(word[idx*4 +: 4]);
        disp.seg_in = seg ^ {7{disp.neg_seg}};
        disp.dp_in  = dts[3-idx] ^ disp.neg_seg;
        disp.sel_in = sel ^ {4{disp.neg_sel}};
        repeat (n) @(negedge clk);
    endtask

    // Full frames 1,2,4,8 followed by the closing sel=1
    task automatic scan_frames(input logic [15:0] word, input logic [3:0] dts,
                               input int nframes, input int bad_frame, input int bad_slot);
        for (int f = 0; f < nframes; f++) begin
            for (int s = 0; s < 4; s++) begin
                drive_sel(4'b0001 << s, word, dts, (f == bad_frame) ? bad_slot : -1, DW);
            end
        end
        drive_sel(4'b0001, word, dts, -1, 6);
    endtask

    task automatic test_reset();
        disp.seg_in = 7'h00; disp.dp_in = 1'b0; disp.sel_in = 4'h0;
        disp.neg_seg = 1'b0; disp.neg_sel = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({min_u, min_d, hrs_u, hrs_d, dots, time_valid, frame_stb, decode_err, scan_lost} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 000000",
                     {min_u, min_d, hrs_u, hrs_d, dots, time_valid, frame_stb, decode_err, scan_lost});
        end
    endtask

    task automatic test_scan_basic();
        scan_frames(16'h1234, 4'h0, 1, -1, -1);
        exp_q.push_back('{word: 16'h1234, dots: 4'h0});
        for (int s = 0; s < 4; s++) drive_sel(4'b0001 << s, 16'h1234, 4'h0, -1, DW);
        drive_sel(4'b0001, 16'h1234, 4'h0, -1, 2);
        n_checks++;
        if (frame_stb !== 1'b0) begin
            n_fail++; $display("FAIL latency_early: frame_stb=%b, expected 0", frame_stb);
        end
        drive_sel(4'b0001, 16'h1234, 4'h0, -1, 1);
        n_checks++;
        if (frame_stb !== 1'b1) begin
            n_fail++; $display("FAIL latency_3rd_cycle: frame_stb=%b, expected 1", frame_stb);
        end
        drive_sel(4'b0001, 16'h1234, 4'h0, -1, 3);
        n_checks++;
        if ({hrs_d, hrs_u, min_d, min_u} !== 16'h1234) begin
            n_fail++; $display("FAIL basic_digits: got %h%h:%h%h, expected 12:34", hrs_d, hrs_u, min_d, min_u);
        end
        n_checks++;
        if ({time_valid, decode_err, frame_stb} !== 3'b100) begin
            n_fail++; $display("FAIL basic_flags: tv/err/stb=%b%b%b, expected 100", time_valid, decode_err, frame_stb);
        end
    endtask

    task automatic test_bad_frame();
        scan_frames(16'h1234, 4'h0, 1, 0, 1);
        n_checks++;
        if ({decode_err, time_valid, hrs_d, hrs_u, min_d, min_u} !== {2'b11, 16'h1234}) begin
            n_fail++; $display("FAIL bad_frame_hold: err/tv=%b%b time %h%h:%h%h, expected 11 12:34",
                               decode_err, time_valid, hrs_d, hrs_u, min_d, min_u);
        end
        exp_q.push_back('{word: 16'h1235, dots: 4'h0});
        scan_frames(16'h1235, 4'h0, 2, -1, -1);
        n_checks++;
        if ({min_u, decode_err} !== {4'd5, 1'b0}) begin
            n_fail++; $display("FAIL bad_frame_recover: min_u=%0d err=%b, expected 5 0", min_u, decode_err);
        end
    endtask

    task automatic test_negated();
        disp.neg_seg = 1'b1; disp.neg_sel = 1'b1;
        drive_sel(4'b0001, 16'h2359, 4'b1000, -1, 2);
        exp_q.push_back('{word: 16'h2359, dots: 4'b1000});
        scan_frames(16'h2359, 4'b1000, 2, -1, -1);
        n_checks++;
        if ({hrs_d, hrs_u, min_d, min_u} !== 16'h2359) begin
            n_fail++; $display("FAIL neg_digits: got %h%h:%h%h, expected 23:59", hrs_d, hrs_u, min_d, min_u);
        end
        n_checks++;
        if (dots !== 4'b1000) begin
            n_fail++; $display("FAIL neg_dots: got %b, expected 1000", dots);
        end
        disp.neg_seg = 1'b0; disp.neg_sel = 1'b0;
        drive_sel(4'b0001, 16'h2359, 4'b1000, -1, 2);
    endtask

    task automatic test_illegal_seq();
        logic [3:0] seq [10] = '{4'd1, 4'd2, 4'd8, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
        for (int i = 0; i < 10; i++) drive_sel(seq[i], 16'h0815, 4'h0, -1, DW);
        n_checks++;
        if ({decode_err, hrs_d, hrs_u, min_d, min_u} !== {1'b0, 16'h2359}) begin
            n_fail++; $display("FAIL illseq_hold: err=%b time %h%h:%h%h, expected 0 23:59",
                               decode_err, hrs_d, hrs_u, min_d, min_u);
        end
        exp_q.push_back('{word: 16'h0815, dots: 4'h0});
        scan_frames(16'h0815, 4'h0, 1, -1, -1);
        n_checks++;
        if ({decode_err, hrs_d, hrs_u, min_d, min_u} !== {1'b0, 16'h0815}) begin
            n_fail++; $display("FAIL illseq_load: err=%b time %h%h:%h%h, expected 0 08:15",
                               decode_err, hrs_d, hrs_u, min_d, min_u);
        end
    endtask

    task automatic test_timeout();
        disp.sel_in = 4'h0;
        repeat (200) @(negedge clk);
        n_checks++;
        if ({scan_lost, time_valid} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_early: lost/tv=%b%b, expected 01", scan_lost, time_valid);
        end
        repeat (100) @(negedge clk);
        n_checks++;
        if ({scan_lost, time_valid, hrs_d, hrs_u, min_d, min_u} !== {2'b10, 16'h0815}) begin
            n_fail++; $display("FAIL tmo_lost: lost/tv=%b%b time %h%h:%h%h, expected 10 08:15",
                               scan_lost, time_valid, hrs_d, hrs_u, min_d, min_u);
        end
        exp_q.push_back('{word: 16'h0815, dots: 4'h0});
        scan_frames(16'h0815, 4'h0, 2, -1, -1);
        n_checks++;
        if ({scan_lost, time_valid} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_resume: lost/tv=%b%b, expected 01", scan_lost, time_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive_sel(4'b0001, 16'h2500, 4'h0, -1, 5);
        drive_sel(4'b0010, 16'h2500, 4'h0, -1, 10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({min_u, min_d, hrs_u, hrs_d, dots, time_valid, frame_stb, decode_err, scan_lost} !== 24'h0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h, expected 000000",
                               {min_u, min_d, hrs_u, hrs_d, dots, time_valid, frame_stb, decode_err, scan_lost});
        end
        for (int f = 0; f < 2; f++) begin
            scan_frames(16'h2500, 4'h0, 1, -1, -1);
            n_checks++;
            if ({decode_err, time_valid, hrs_d, hrs_u, min_d, min_u} !== {2'b10, 16'h0000}) begin
                n_fail++; $display("FAIL range_frame%0d: err/tv=%b%b time %h%h:%h%h, expected 10 00:00",
                                   f, decode_err, time_valid, hrs_d, hrs_u, min_d, min_u);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan_basic();
        test_bad_frame();
        test_negated();
        test_illegal_seq();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d expected loads never seen, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_display_decoder.md
Name: mux_display_decoder

Overview:
- Receiving end of the multiplexed 7-segment clock display interface.
- Samples the segment bus, decimal-point line and one-hot digit selector, and decodes each digit slot back to BCD.
- Reassembles HH:MM plus the four quarter-minute dot LEDs, and publishes the time only after it is stable across consecutive scan frames.
- Used for display loopback self-test and for board-level readback of the clock.

Parameters:
- SCAN_TIMEOUT, 256: clock cycles with no legal selector transition before the scan is declared lost.
- STABLE_FRAMES, 2: consecutive identical error-free frames required before outputs update (range 1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg_in  input  7  segment bus, bit0=a .. bit6=g
- dp_in  input  1  decimal-point line
- sel_in  input  4  digit selector, one-hot: 1=min units, 2=min tens, 4=hrs units, 8=hrs tens
- neg_seg  input  1  1 = seg_in/dp_in are active-low
- neg_sel  input  1  1 = sel_in is active-low
- min_u  output  4  decoded minute units
- min_d  output  4  decoded minute tens
- hrs_u  output  4  decoded hour units
- hrs_d  output  4  decoded hour tens
- dots  output  4  {dp@sel1, dp@sel2, dp@sel4, dp@sel8}
- time_valid  output  1  outputs hold a confirmed time
- frame_stb  output  1  one-cycle pulse when outputs are loaded
- decode_err  output  1  sticky until the next good frame; last completed frame was bad
- scan_lost  output  1  selector activity timed out

Behaviour:
- Reset (one clk edge with reset=1): all outputs 0; internal visited mask, match count and timeout counter are cleared. Reset mid-frame discards the partial frame.
- Input stage: seg_in, dp_in, sel_in are XORed with their negate controls, then registered once (stage S1). All further logic uses S1 values.
- Segment decode table, {g..a} hex to digit: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7C=6, 07=7, 7F=8, 67=9. Any other code (including 00) is invalid.
- Slot hold: while S1 sel is a legal one-hot value equal to prev_sel, the hold register takes decode(S1 seg) and the dp bit every cycle. The last-dwell-cycle value is the one committed.
- Transition (S1 sel != prev_sel, both one-hot):
  - Commit the hold register into the prev_sel slot and set that bit of the visited mask.
  - Legal transition = S1 sel equals rotate-left(prev_sel): 1→2→4→8→1. A legal transition resets the timeout counter.
  - Illegal transition: clear the visited mask and abandon the frame. No error flag; the partial frame is simply discarded.
- Non-one-hot S1 sel (0 or multi-hot): no capture, prev_sel unchanged, timeout keeps counting. When one-hot resumes, the transition rule applies against the stored prev_sel.
- Frame end: a legal 8→1 transition with the visited mask = 1111 after the commit. The frame is good only if:
  - all four slots are valid digits;
  - min_d ≤ 5 and hrs_d ≤ 2;
  - hrs_d*10 + hrs_u ≤ 23.
  - The mask is cleared after evaluation either way.
- Good frame:
  - If it equals the candidate, increment the match count (saturating).
  - Otherwise load the candidate and set match = 1.
  - When match reaches STABLE_FRAMES (including the same frame when STABLE_FRAMES=1):
    - outputs load from the candidate;
    - time_valid=1, frame_stb=1 for one cycle;
    - decode_err=0, scan_lost=0.
  - Further identical frames re-pulse frame_stb; outputs are unchanged.
- Bad frame: decode_err=1, match=0; outputs and time_valid are held.
- Latency: frame_stb is high in the 3rd cycle after the first clk edge that samples raw sel_in=1 following sel_in=8 (1 cycle input register, 1 cycle transition detect, 1 cycle output register).
- Timeout:
  - The counter increments each cycle without a legal transition.
  - Reaching SCAN_TIMEOUT sets scan_lost=1 and time_valid=0, clears the match count and visited mask, and holds the digit outputs.
  - The counter saturates.
  - scan_lost clears only on the next frame_stb.
- Simultaneous events: a timeout on the same cycle as a frame end is ignored, because the legal transition resets the counter first.

Test Plan:
- Scan 12:34 (sel rotate 1,2,4,8, 33-cycle dwell, seg per table, no negation) for 2 frames → frame_stb once at end of frame 2; min_u=4, min_d=3, hrs_u=2, hrs_d=1, time_valid=1, decode_err=0.
- neg_seg=1, neg_sel=1, scanning 23:59 with inverted inputs and dp high only on sel=1 → after 2 frames: hrs_d=2, hrs_u=3, min_d=5, min_u=9, dots=1000.
- After valid 12:34, one frame carries seg 00 on sel=2, then 12:35 for 2 frames → decode_err=1 with outputs still 12:34 after the bad frame; after the 2nd 12:35 frame min_u=5, decode_err=0.
- Sequence 1,2,8,4,8,1,2,4,8,1, then 1 more full frame → no frame_stb until 2 clean rotations complete; no decode_err.
- Hold sel_in=0 for 300 cycles after valid time → scan_lost=1 at cycle 256 of inactivity, time_valid=0, digits held; resume 2 frames → scan_lost=0, frame_stb.
- Assert reset mid-frame, then scan 2 frames of 25:00 → all outputs 0 after reset; decode_err=1 after each frame, time_valid stays 0.
